// File: rtl/keypad_pkg.sv
// Shared types and geometry for the 4x8 key matrix scanner.
package keypad_pkg;
    localparam int KP_COLS   = 4;
    localparam int KP_ROWS   = 8;
    localparam int KP_CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } kp_frame_e;
endpackage

// File: rtl/keypad_frame_collector.sv
// Drives the column strobe, samples the synchronized rows once per column
// and classifies each complete 4-column frame as NONE, SINGLE or MULTI.
module keypad_frame_collector
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KP_ROWS-1:0]   io_row,
    output logic [KP_COLS-1:0]   io_col,
    output logic                 frame_done,
    output kp_frame_e            frame_result,
    output logic [KP_CODE_W-1:0] frame_code
);
    localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);

    logic [DW-1:0]        dwell;
    logic [1:0]           col_idx;
    logic [KP_ROWS-1:0]   sync1, sync2;
    logic [KP_ROWS-1:0]   row_act;
    logic [KP_ROWS-1:0]   samp0, samp1, samp2;
    logic                 dwell_last;
    logic [31:0]          frame_bits;
    logic [5:0]           hits;

    assign row_act    = ~sync2;
    assign dwell_last = (dwell == DWELL_LAST);
    assign frame_done = dwell_last && (col_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            col_idx <= 2'd0;
            io_col  <= 4'b1110;
            sync1   <= '1;
            sync2   <= '1;
            samp0   <= '0;
            samp1   <= '0;
            samp2   <= '0;
        end else begin
            sync1 <= io_row;
            sync2 <= sync1;
            if (dwell_last) begin
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
                io_col  <= ~(4'b0001 << (col_idx + 2'd1));
                case (col_idx)
                    2'd0:    samp0 <= row_act;
                    2'd1:    samp1 <= row_act;
                    2'd2:    samp2 <= row_act;
                    default: ;
                endcase
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Column 3 is classified straight from the live sample; bit index = {col,row}.
    assign frame_bits = {row_act, samp2, samp1, samp0};

    always_comb begin
        hits       = '0;
        frame_code = '0;
        for (int i = 0; i < 32; i++) begin
            if (frame_bits[i]) begin
                hits       = hits + 6'd1;
                frame_code = KP_CODE_W'(i);
            end
        end
        if (hits == 6'd0)      frame_result = NONE;
        else if (hits == 6'd1) frame_result = SINGLE;
        else                   frame_result = MULTI;
    end
endmodule

// File: rtl/matrix_keypad_scanner.sv
// Debounced single-key scanner: frame collector plus per-key debounce FSM.
// IDLE no key | DEBOUNCE counting matching frames | HELD accepted | RELEASE counting non-matching frames
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1024,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [KP_COLS-1:0]   io_col,
    input  logic [KP_ROWS-1:0]   io_row,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_pressed
);
    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic                 frame_done;
    kp_frame_e            frame_result;
    logic [KP_CODE_W-1:0] frame_code;

    kp_state_e            state, state_n;
    logic [KP_CODE_W-1:0] cand, cand_n;
    logic [3:0]           cnt, cnt_n, cnt_inc;
    logic                 accept, release_done, is_cand;

    keypad_frame_collector #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_collector (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_row       (io_row),
        .io_col       (io_col),
        .frame_done   (frame_done),
        .frame_result (frame_result),
        .frame_code   (frame_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_valid <= accept;
            if (accept) begin
                key_code    <= cand_n;
                key_pressed <= 1'b1;
            end else if (release_done) begin
                key_pressed <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n      = state;
        cand_n       = cand;
        cnt_n        = cnt;
        accept       = 1'b0;
        release_done = 1'b0;
        is_cand      = (frame_result == SINGLE) && (frame_code == cand);
        cnt_inc      = (cnt < DEB_N) ? cnt + 4'd1 : cnt;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_result == SINGLE) begin
                        cand_n = frame_code;
                        if (DEB_N == 4'd1) begin
                            state_n = HELD;
                            cnt_n   = '0;
                            accept  = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (is_cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DEB_N) begin
                            state_n = HELD;
                            cnt_n   = '0;
                            accept  = 1'b1;
                        end
                    end else if (frame_result == SINGLE) begin
                        cand_n = frame_code;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (!is_cand) begin
                        if (DEB_N == 4'd1) begin
                            state_n      = IDLE;
                            cnt_n        = '0;
                            release_done = 1'b1;
                        end else begin
                            state_n = RELEASE;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                RELEASE: begin
                    if (is_cand) begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DEB_N) begin
                            state_n      = IDLE;
                            cnt_n        = '0;
                            release_done = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: doc/matrix_keypad_scanner.md
# matrix_keypad_scanner

Scans a 4-column × 8-row passive key matrix and reports debounced single-key press events. It is the input-side counterpart of the seven-segment matrix display driver. It shares the same active-low column strobe scheme and the same 4×8 geometry, so both can sit on one tile's IO. Rows are sampled through a synchronizer, each full scan frame is classified, and a per-key debounce FSM emits a one-cycle `key_valid` pulse with a 5-bit key code.

## Interface
- `SETTLE_CYCLES`, default 1024: clock cycles each column stays driven per dwell; minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical frames required to accept a press or a release; range 1–15.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `io_col`  out  4  column drive, active-low one-hot; reset `4'b1110`.
- `io_row`  in  8  row sense, active-low (pulled up externally); asynchronous to `clk`.
- `key_code`  out  5  `{col_idx[1:0], row_idx[2:0]}` of the accepted key; reset 0; holds its value until the next accepted press.
- `key_valid`  out  1  one-cycle pulse on press acceptance; reset 0.
- `key_pressed`  out  1  level, high from acceptance until release is accepted; reset 0.

## Operation
- **Column scan.**
  - A dwell counter runs 0..SETTLE_CYCLES-1.
  - On wrap, `col_idx` advances 0→1→2→3→0, and `io_col` = ~(1<<col_idx).
  - 4 dwells form one frame.
- **Row input.**
  - `io_row` passes through a 2-flop synchronizer, then is inverted to give `row_act[7:0]`.
- **Sampling.**
  - `row_act` is sampled on the last dwell cycle (count = SETTLE_CYCLES-1) of each column.
  - This leaves ≥2 cycles of synchronizer settling after the column change.
- **Frame classification**, evaluated on the last dwell cycle of column 3:
  - NONE: 0 active bits across all 4 samples.
  - SINGLE(code): exactly 1 active bit.
  - MULTI: ≥2 active bits. Ghosting is rejected; MULTI never produces a key.
- **FSM states:** IDLE, DEBOUNCE, HELD, RELEASE. State is updated only at frame end.
  - IDLE:
    - SINGLE(c) → DEBOUNCE, cand=c, cnt=1.
    - If DEBOUNCE_SCANS=1, go directly to HELD and accept.
  - DEBOUNCE:
    - SINGLE(cand): cnt+1; when cnt reaches DEBOUNCE_SCANS → HELD and accept.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI → IDLE, cnt=0.
  - Accept means: `key_code`←cand, `key_valid`=1 for exactly one cycle, `key_pressed`←1.
  - HELD:
    - SINGLE(cand) stays in HELD.
    - Anything else (NONE, MULTI, a different key) → RELEASE, cnt=1.
  - RELEASE:
    - SINGLE(cand) → HELD, cnt=0. A bounce is absorbed and no new pulse is emitted.
    - Otherwise cnt+1; when cnt reaches DEBOUNCE_SCANS → IDLE, `key_pressed`←0.
  - After release, a different key held continuously is accepted by the normal IDLE→DEBOUNCE path; no scan is skipped.
- **Widths.** cnt is 4 bits and saturates at DEBOUNCE_SCANS. The dwell counter is $clog2(SETTLE_CYCLES) bits.
- **Reset** (any time, including mid-frame or mid-debounce):
  - All outputs go to their reset values; FSM → IDLE.
  - Counters, sample registers and synchronizer are cleared; the scan restarts at column 0.

## Timing
- `key_valid` and `key_pressed` rise in the cycle after the frame-end sample cycle of the accepting frame.
- `key_code` updates in that same cycle.
- Press latency, for a press stable before a frame starts: DEBOUNCE_SCANS×4×SETTLE_CYCLES + 1 cycles from frame start.
- Release latency: from the first non-matching frame end, (DEBOUNCE_SCANS−1) further frames, then `key_pressed` falls 1 cycle after the last frame end.
- `io_col` changes in the cycle after the dwell wrap and is registered; no glitches.
- At most one `key_valid` pulse per frame; pulses are at least 4×SETTLE_CYCLES apart.

## Structure
- Shared package `keypad_pkg`:
  - FSM state enum (IDLE, DEBOUNCE, HELD, RELEASE).
  - Frame result enum (NONE, SINGLE, MULTI).
  - Constants `KP_COLS=4`, `KP_ROWS=8`, `KP_CODE_W=5`.
- Sub-module `keypad_frame_collector`:
  - Contains the synchronizer, dwell/column counters, per-column sampling and popcount/encode logic.
  - Outputs a 1-cycle `frame_done` together with result and code.
- The top level holds the debounce FSM and the output registers.

## Test plan
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=3; frame = 16 cycles.
- **Reset.** Release `rst_n` → `io_col`=1110, then 1101 after 4 cycles, 1011, 0111, 1110 repeating; all key outputs 0. Assert `rst_n` mid-frame → `io_col`=1110 immediately.
- **Clean press.** Drive `io_row[5]` low only while `io_col`=1011 (col 2), held for 5 frames → exactly one `key_valid` pulse, `key_code`=5'b10101, 1 cycle after the 3rd frame end; `key_pressed` stays high.
- **Bounce.** Press toggles every 5 cycles for 2 frames, then holds → no pulse until 3 clean consecutive frames; exactly one pulse. During HELD, one NONE frame followed by return → no new pulse, `key_pressed` stays 1.
- **Release.** Drop the key → `key_pressed` falls 1 cycle after the 3rd NONE frame end; `key_code` retains 5'b10101.
- **Ghosting.** Keys (col0,row1) and (col3,row7) pressed together for 6 frames → no `key_valid`. Remove the col3 key → valid after 3 frames with `key_code`=5'b00001.
- **Reset mid-debounce.** Assert `rst_n` after 2 matching frames, release it, continue the press → pulse only after 3 full new frames.
